// File: rtl/rob_pkg.sv
// Shared ROB width constants, retire FSM state encoding and index helper.
package rob_pkg;

    localparam int PHYS_W    = 7;
    localparam int ROB_IDX_W = 8;
    localparam int PC_W      = 64;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        WAIT  = 2'd2
    } retire_state_e;

    // Successor of a ROB index; the natural width overflow gives the 255->0 wrap.
    function automatic logic [ROB_IDX_W-1:0] next_rob_idx(input logic [ROB_IDX_W-1:0] idx);
        return idx + ROB_IDX_W'(1'b1);
    endfunction

endpackage

// File: rtl/rob_retire_ctrl_if.sv
// Bundle of the commit, free-list, LSQ and redirect signals around the retire controller.
interface rob_retire_ctrl_if;
    import rob_pkg::*;

    logic                 commit_valid_i;
    logic [ROB_IDX_W-1:0] commit_idx_i;
    logic [PHYS_W-1:0]    commit_rd_phys_i;
    logic [PHYS_W-1:0]    commit_old_phys_i;
    logic                 commit_is_store_i;
    logic                 commit_branch_misp_i;
    logic [PC_W-1:0]      commit_branch_target_i;
    logic                 commit_ready_o;
    logic                 free_valid_o;
    logic [PHYS_W-1:0]    free_phys_o;
    logic                 free_ready_i;
    logic                 store_commit_valid_o;
    logic                 flush_o;
    logic                 redirect_valid_o;
    logic [PC_W-1:0]      redirect_pc_o;
    logic                 flush_done_i;
    logic [63:0]          retire_count_o;
    logic                 err_o;

    // Retire controller side.
    modport slave (
        input  commit_valid_i, commit_idx_i, commit_rd_phys_i, commit_old_phys_i,
               commit_is_store_i, commit_branch_misp_i, commit_branch_target_i,
               free_ready_i, flush_done_i,
        output commit_ready_o, free_valid_o, free_phys_o, store_commit_valid_o,
               flush_o, redirect_valid_o, redirect_pc_o, retire_count_o, err_o
    );

    // ROB / free list / LSQ / front-end side.
    modport master (
        output commit_valid_i, commit_idx_i, commit_rd_phys_i, commit_old_phys_i,
               commit_is_store_i, commit_branch_misp_i, commit_branch_target_i,
               free_ready_i, flush_done_i,
        input  commit_ready_o, free_valid_o, free_phys_o, store_commit_valid_o,
               flush_o, redirect_valid_o, redirect_pc_o, retire_count_o, err_o
    );

endinterface

// File: rtl/retire_free_fifo.sv
// Small synchronous FIFO holding physical registers waiting to return to the free list.
// A push into a full FIFO and a pop from an empty FIFO are ignored; the caller flags the former.
module retire_free_fifo
    import rob_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [PHYS_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [PHYS_W-1:0] head_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [AW:0]       free_slots_o
);

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [PHYS_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign empty_o      = (count_q == {(AW + 1){1'b0}});
    assign full_o       = (count_q == DEPTH_C);
    assign free_slots_o = DEPTH_C - count_q;
    assign head_o       = mem_q[rd_ptr_q];
    assign push_ok_s    = push_i && !full_o;
    assign pop_ok_s     = pop_i && !empty_o;

    // Storage, pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {PHYS_W{1'b0}};
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW + 1){1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + (AW + 1)'(1'b1);
                2'b01:   count_q <= count_q - (AW + 1)'(1'b1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/rob_retire_ctrl.sv
// Retire controller: turns ROB commits into free-list returns, store releases and
// retirement counts, and sequences flush/redirect on a committed branch mispredict.
module rob_retire_ctrl
    import rob_pkg::*;
#(
    parameter int FREE_FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    rob_retire_ctrl_if.slave bus
);

    localparam int SLOT_W = $clog2(FREE_FIFO_DEPTH) + 1;

    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_FLUSH = FLUSH;
    localparam logic [1:0] ST_WAIT  = WAIT;

    logic [1:0]           state_q,     state_d;
    logic                 exp_valid_q, exp_valid_d;
    logic [ROB_IDX_W-1:0] last_idx_q,  last_idx_d;
    logic                 err_q,       err_d;
    logic                 store_q,     store_d;
    logic                 flush_q,     flush_d;
    logic [PC_W-1:0]      redir_pc_q,  redir_pc_d;
    logic [63:0]          count_q,     count_d;

    logic                 accept_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 order_err_s;
    logic [PHYS_W-1:0]    head_s;
    logic                 empty_s;
    logic                 full_s;
    logic [SLOT_W-1:0]    free_slots_s;

    assign accept_s    = bus.commit_valid_i && (state_q == ST_RUN);
    assign push_s      = accept_s && (bus.commit_old_phys_i != {PHYS_W{1'b0}});
    assign pop_s       = !empty_s && bus.free_ready_i;
    assign order_err_s = accept_s && exp_valid_q &&
                         (bus.commit_idx_i != next_rob_idx(last_idx_q));

    retire_free_fifo #(
        .DEPTH (FREE_FIFO_DEPTH)
    ) u_free_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push_s),
        .push_data_i  (bus.commit_old_phys_i),
        .pop_i        (pop_s),
        .head_o       (head_s),
        .empty_o      (empty_s),
        .full_o       (full_s),
        .free_slots_o (free_slots_s)
    );

    // One slot stays reserved for the commit already in flight from the ROB.
    assign bus.commit_ready_o = (state_q == ST_RUN) &&
                                (free_slots_s >= SLOT_W'(2'd2)) &&
                                !(bus.commit_valid_i && bus.commit_branch_misp_i);

    assign bus.free_valid_o         = !empty_s;
    assign bus.free_phys_o          = head_s;
    assign bus.store_commit_valid_o = store_q;
    assign bus.flush_o              = flush_q;
    assign bus.redirect_valid_o     = flush_q;
    assign bus.redirect_pc_o        = redir_pc_q;
    assign bus.retire_count_o       = count_q;
    assign bus.err_o                = err_q;

    // Next-state for the FSM, ordering tracker, pulses, counter and sticky error.
    always_comb begin
        state_d     = state_q;
        exp_valid_d = exp_valid_q;
        last_idx_d  = last_idx_q;
        err_d       = err_q;
        store_d     = 1'b0;
        flush_d     = 1'b0;
        redir_pc_d  = redir_pc_q;
        count_d     = count_q;

        if (accept_s) begin
            count_d     = count_q + 64'd1;
            store_d     = bus.commit_is_store_i;
            exp_valid_d = 1'b1;
            last_idx_d  = bus.commit_idx_i;
        end else begin
            count_d = count_q;
        end

        if (order_err_s || (push_s && full_s)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end

        case (state_q)
            ST_RUN: begin
                if (accept_s && bus.commit_branch_misp_i) begin
                    state_d    = ST_FLUSH;
                    flush_d    = 1'b1;
                    redir_pc_d = bus.commit_branch_target_i;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.flush_done_i) begin
                    state_d     = ST_RUN;
                    exp_valid_d = 1'b0;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            exp_valid_q <= 1'b0;
            last_idx_q  <= {ROB_IDX_W{1'b0}};
            err_q       <= 1'b0;
            store_q     <= 1'b0;
            flush_q     <= 1'b0;
            redir_pc_q  <= {PC_W{1'b0}};
            count_q     <= 64'd0;
        end else begin
            state_q     <= state_d;
            exp_valid_q <= exp_valid_d;
            last_idx_q  <= last_idx_d;
            err_q       <= err_d;
            store_q     <= store_d;
            flush_q     <= flush_d;
            redir_pc_q  <= redir_pc_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: tb/tb_rob_retire_ctrl.sv
// Directed self-checking bench for rob_retire_ctrl.
module tb_rob_retire_ctrl;
    import rob_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    rob_retire_ctrl_if bus_if ();

    rob_retire_ctrl #(
        .FREE_FIFO_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] idx, input logic [6:0] old_phys,
                         input logic store, input logic misp, input logic [63:0] tgt);
        bus_if.commit_valid_i         = 1'b1;
        bus_if.commit_idx_i           = idx;
        bus_if.commit_rd_phys_i       = old_phys + 7'd64;
        bus_if.commit_old_phys_i      = old_phys;
        bus_if.commit_is_store_i      = store;
        bus_if.commit_branch_misp_i   = misp;
        bus_if.commit_branch_target_i = tgt;
    endtask

    task automatic idle();
        bus_if.commit_valid_i       = 1'b0;
        bus_if.commit_is_store_i    = 1'b0;
        bus_if.commit_branch_misp_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},  {63'd0, bus_if.commit_ready_o},       64'd1);
        check({tag, "_fvalid"}, {63'd0, bus_if.free_valid_o},         64'd0);
        check({tag, "_fphys"},  {57'd0, bus_if.free_phys_o},          64'd0);
        check({tag, "_store"},  {63'd0, bus_if.store_commit_valid_o}, 64'd0);
        check({tag, "_flush"},  {63'd0, bus_if.flush_o},              64'd0);
        check({tag, "_redir"},  {63'd0, bus_if.redirect_valid_o},     64'd0);
        check({tag, "_pc"},     bus_if.redirect_pc_o,                 64'd0);
        check({tag, "_count"},  bus_if.retire_count_o,                64'd0);
        check({tag, "_err"},    {63'd0, bus_if.err_o},                64'd0);
    endtask

    initial begin
        clk   = 1'b0;
        rst   = 1'b1;
        n_cmp = 0;
        n_bad = 0;
        bus_if.commit_idx_i           = 8'd0;
        bus_if.commit_rd_phys_i       = 7'd0;
        bus_if.commit_old_phys_i      = 7'd0;
        bus_if.commit_branch_target_i = 64'd0;
        bus_if.free_ready_i           = 1'b1;
        bus_if.flush_done_i           = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_reset_outputs("reset");

        // Basic retire: idx 0..3, old phys 5,0,9,12, free list always ready.
        drive(8'd0, 7'd5, 1'b0, 1'b0, 64'd0);
        tick();
        check("basic_fv0", {63'd0, bus_if.free_valid_o}, 64'd1);
        check("basic_fp0", {57'd0, bus_if.free_phys_o}, 64'd5);
        drive(8'd1, 7'd0, 1'b0, 1'b0, 64'd0);
        tick();
        check("basic_p0_not_freed", {63'd0, bus_if.free_valid_o}, 64'd0);
        drive(8'd2, 7'd9, 1'b0, 1'b0, 64'd0);
        tick();
        check("basic_fp2", {57'd0, bus_if.free_phys_o}, 64'd9);
        drive(8'd3, 7'd12, 1'b0, 1'b0, 64'd0);
        tick();
        check("basic_fp3", {57'd0, bus_if.free_phys_o}, 64'd12);
        check("basic_count", bus_if.retire_count_o, 64'd4);
        check("basic_err", {63'd0, bus_if.err_o}, 64'd0);
        idle();
        tick();
        check("basic_drained", {63'd0, bus_if.free_valid_o}, 64'd0);

        // Backpressure: free list stalled, three entries held.
        bus_if.free_ready_i = 1'b0;
        drive(8'd4, 7'd1, 1'b0, 1'b0, 64'd0);
        tick();
        idle();
        #1;
        check("bp_ready1", {63'd0, bus_if.commit_ready_o}, 64'd1);
        drive(8'd5, 7'd2, 1'b0, 1'b0, 64'd0);
        tick();
        idle();
        #1;
        check("bp_ready2", {63'd0, bus_if.commit_ready_o}, 64'd1);
        drive(8'd6, 7'd3, 1'b0, 1'b0, 64'd0);
        tick();
        idle();
        #1;
        check("bp_ready3", {63'd0, bus_if.commit_ready_o}, 64'd0);
        check("bp_head1", {57'd0, bus_if.free_phys_o}, 64'd1);
        check("bp_err", {63'd0, bus_if.err_o}, 64'd0);
        bus_if.free_ready_i = 1'b1;
        tick();
        check("bp_head2", {57'd0, bus_if.free_phys_o}, 64'd2);
        check("bp_ready_back", {63'd0, bus_if.commit_ready_o}, 64'd1);
        tick();
        check("bp_head3", {57'd0, bus_if.free_phys_o}, 64'd3);
        tick();
        check("bp_empty", {63'd0, bus_if.free_valid_o}, 64'd0);

        // Store release pulse.
        drive(8'd7, 7'd0, 1'b1, 1'b0, 64'd0);
        tick();
        check("store_hi", {63'd0, bus_if.store_commit_valid_o}, 64'd1);
        idle();
        tick();
        check("store_lo", {63'd0, bus_if.store_commit_valid_o}, 64'd0);
        drive(8'd8, 7'd0, 1'b0, 1'b0, 64'd0);
        tick();
        drive(8'd9, 7'd0, 1'b0, 1'b0, 64'd0);
        tick();
        check("pre_misp_count", bus_if.retire_count_o, 64'd10);

        // Mispredict at idx 10, then a wrong-path commit the next cycle.
        drive(8'd10, 7'd20, 1'b0, 1'b1, 64'h8000_1000);
        #1;
        check("misp_ready_n", {63'd0, bus_if.commit_ready_o}, 64'd0);
        tick();
        check("misp_flush", {63'd0, bus_if.flush_o}, 64'd1);
        check("misp_redir", {63'd0, bus_if.redirect_valid_o}, 64'd1);
        check("misp_pc", bus_if.redirect_pc_o, 64'h8000_1000);
        check("misp_count", bus_if.retire_count_o, 64'd11);
        check("misp_freed", {57'd0, bus_if.free_phys_o}, 64'd20);
        drive(8'd11, 7'd30, 1'b1, 1'b0, 64'd0);
        #1;
        check("flush_ready", {63'd0, bus_if.commit_ready_o}, 64'd0);
        tick();
        idle();
        check("flush_pulse_end", {63'd0, bus_if.flush_o}, 64'd0);
        check("redir_pulse_end", {63'd0, bus_if.redirect_valid_o}, 64'd0);
        check("drop_count", bus_if.retire_count_o, 64'd11);
        check("drop_store", {63'd0, bus_if.store_commit_valid_o}, 64'd0);
        check("drop_nofree", {63'd0, bus_if.free_valid_o}, 64'd0);
        check("pc_held", bus_if.redirect_pc_o, 64'h8000_1000);
        tick();
        tick();
        check("wait_ready", {63'd0, bus_if.commit_ready_o}, 64'd0);
        bus_if.flush_done_i = 1'b1;
        #1;
        check("done_ready_same", {63'd0, bus_if.commit_ready_o}, 64'd0);
        tick();
        bus_if.flush_done_i = 1'b0;
        check("done_ready_next", {63'd0, bus_if.commit_ready_o}, 64'd1);
        check("misp_err", {63'd0, bus_if.err_o}, 64'd0);

        // Ordering with wrap, tracking restarted after the flush.
        drive(8'd254, 7'd0, 1'b0, 1'b0, 64'd0);
        tick();
        drive(8'd255, 7'd0, 1'b0, 1'b0, 64'd0);
        tick();
        drive(8'd0, 7'd0, 1'b0, 1'b0, 64'd0);
        tick();
        check("wrap_err", {63'd0, bus_if.err_o}, 64'd0);
        drive(8'd2, 7'd0, 1'b0, 1'b0, 64'd0);
        tick();
        idle();
        check("order_err", {63'd0, bus_if.err_o}, 64'd1);
        tick();
        tick();
        check("order_err_sticky", {63'd0, bus_if.err_o}, 64'd1);
        check("order_count", bus_if.retire_count_o, 64'd15);

        // Reset while in WAIT with a pending free held back.
        bus_if.free_ready_i = 1'b0;
        drive(8'd3, 7'd40, 1'b0, 1'b1, 64'h1234);
        tick();
        idle();
        tick();
        check("rst_pre_pending", {63'd0, bus_if.free_valid_o}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        tick();
        rst = 1'b0;
        bus_if.free_ready_i = 1'b1;
        drive(8'd50, 7'd7, 1'b0, 1'b0, 64'd0);
        #1;
        check("post_rst_ready", {63'd0, bus_if.commit_ready_o}, 64'd1);
        tick();
        idle();
        check("post_rst_count", bus_if.retire_count_o, 64'd1);
        check("post_rst_free", {57'd0, bus_if.free_phys_o}, 64'd7);
        check("post_rst_err", {63'd0, bus_if.err_o}, 64'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rob_retire_ctrl.md
# rob_retire_ctrl

Consumes the reorder buffer commit stream one entry per cycle and turns each retired micro-op into its architectural side effects. It returns the previous physical destination to the rename free list, pulses store release to the LSQ, and counts retirements. On a committed branch mispredict it runs a flush/redirect sequence. It sits between the ROB commit port and the rename free list, LSQ and front-end redirect path.

## Interface
- FREE_FIFO_DEPTH, 4, depth of the free-list return FIFO; power of two, ≥2.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- commit_valid_i  in  1  ROB commit valid; registered one cycle after the ROB samples commit_ready_o.
- commit_idx_i  in  8  ROB index of the committing entry.
- commit_rd_phys_i  in  7  new physical destination (informational).
- commit_old_phys_i  in  7  previous physical mapping to free.
- commit_is_store_i  in  1  entry is a store.
- commit_branch_misp_i  in  1  entry is a mispredicted branch.
- commit_branch_target_i  in  64  correct target for a mispredicted branch.
- commit_ready_o  out  1  permission for the ROB to commit next cycle.
- free_valid_o  out  1  free-list return valid.
- free_phys_o  out  7  physical register being freed.
- free_ready_i  in  1  free list accepts the entry.
- store_commit_valid_o  out  1  one-cycle store release pulse to the LSQ.
- flush_o  out  1  one-cycle pipeline flush pulse.
- redirect_valid_o  out  1  front-end redirect, coincident with flush_o.
- redirect_pc_o  out  64  redirect target.
- flush_done_i  in  1  all structures report flush complete.
- retire_count_o  out  64  accepted commits since reset.
- err_o  out  1  sticky protocol error.

## Operation
- States: RUN, FLUSH, WAIT. Reset enters RUN.
- **Accept rule:**
  - A commit is accepted when commit_valid_i=1 and state=RUN.
  - A commit_valid_i arriving in FLUSH or WAIT is wrong-path and is dropped without side effects. It does not set err_o.
- **commit_ready_o:**
  - Combinational.
  - Equals state==RUN && FIFO free slots ≥2 (one slot reserved for the commit already in flight) && !(commit_valid_i && commit_branch_misp_i).
- **Accepted commit with commit_old_phys_i≠0:**
  - Pushes commit_old_phys_i into the free FIFO.
  - Physical register 0 is never freed.
- **Push while full:** the entry is dropped and err_o is set.
- **Free FIFO output:**
  - free_valid_o = !empty; free_phys_o = head entry.
  - Pop on free_valid_o && free_ready_i.
  - Push and pop in the same cycle are both honoured.
- **Accepted store:** store_commit_valid_o pulses.
- **Ordering check:**
  - Tracks the expected index, initialised by the first accepted commit after reset or after WAIT→RUN.
  - Each subsequent accepted commit must carry expected+1, mod 256, with 255→0 wrap.
  - A mismatch sets err_o.
  - After a mismatch, tracking resyncs to the received index.
- **Accepted commit with commit_branch_misp_i=1:**
  - retire_count increments.
  - The old phys is still freed.
  - redirect_pc latches commit_branch_target_i.
  - State → FLUSH.
- **FLUSH:** lasts exactly one cycle, then WAIT.
- **WAIT:**
  - Stays in WAIT until flush_done_i=1, then → RUN.
  - flush_done_i is ignored outside WAIT.
- **Counters and errors:**
  - retire_count_o is a 64-bit wrapping counter incremented once per accepted commit.
  - err_o clears only on reset.

## Timing
- **Reset values:**
  - commit_ready_o=1 (RUN, FIFO empty).
  - free_valid_o=0, free_phys_o=0, store_commit_valid_o=0, flush_o=0, redirect_valid_o=0, redirect_pc_o=0, retire_count_o=0, err_o=0.
  - FIFO empty.
- **Commit accepted in cycle N:**
  - free_valid_o rises in N+1 if the FIFO was empty.
  - store_commit_valid_o is high in N+1 only.
  - retire_count_o is updated in N+1.
- **Mispredict accepted in cycle N:**
  - commit_ready_o=0 in N.
  - flush_o=redirect_valid_o=1 in N+1 only, with redirect_pc_o valid in N+1 and held until the next mispredict.
  - WAIT from N+2.
- **flush_done_i sampled high in WAIT at cycle M:** RUN at M+1, and commit_ready_o may be 1 in M+1.
- **Free FIFO:**
  - Drains during FLUSH/WAIT independently of state.
  - Entries freed before the flush remain valid and are not discarded.
- **Mid-operation reset:** returns all state, FIFO contents and outputs to reset values immediately (async). No pending free or redirect survives.

## Structure
- Shared package rob_pkg:
  - PHYS_W=7, ROB_IDX_W=8, PC_W=64.
  - retire_state_e {RUN, FLUSH, WAIT}.
  - The ROB reuses the width constants.
- Sub-module retire_free_fifo:
  - Parameterised synchronous FIFO, PHYS_W wide, FREE_FIFO_DEPTH deep.
  - Ports: push, pop, empty, full, free-slot count.
- Top level holds the FSM, ordering checker, counters and output registers.

## Test plan
- **Basic retire:** commits idx 0..3 with old_phys 5,0,9,12, free_ready_i=1 → free_phys_o 5, 9, 12 each one cycle after its commit. retire_count_o=4, err_o=0.
- **Backpressure:** free_ready_i=0, depth 4, commits with old_phys 1..3 → commit_ready_o falls once 3 entries are held. No drop, err_o=0. Releasing free_ready_i drains in order 1, 2, 3.
- **Store:** commit idx 7 with is_store=1 → store_commit_valid_o high exactly one cycle.
- **Mispredict:**
  - Stimulus: commit idx 10 with misp=1 and target 0x8000_1000, plus a further commit_valid_i in the next cycle.
  - Response: flush_o=redirect_valid_o=1 for one cycle with redirect_pc_o=0x8000_1000. The second commit is dropped (count unchanged). commit_ready_o stays 0 until one cycle after flush_done_i.
- **Order/wrap:** commits idx 254, 255, 0 → err_o=0. A following idx 2 → err_o=1 and stays 1.
- **Reset mid-flush:** rst asserted in WAIT → all outputs return to reset values and state is RUN.
